// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the sequential binary-to-BCD converter
// Purpose: FSM state encoding, nibble width and the digit-count legality helper.
// Ports: none (package).
package bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest digit count d with 10^d > 2^width, i.e. enough digits to hold
  // every magnitude up to and including 2^width.
  function automatic int min_bcd_digits(input int width);
    longint unsigned lim;
    longint unsigned pow10;
    int              d;
    lim   = 64'd1 << width;
    pow10 = 64'd10;
    d     = 1;
    while (pow10 <= lim) begin
      pow10 = pow10 * 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one double-dabble iteration: add-3 correction then shift-in
// Purpose: combinational step of the shift/add-3 algorithm over DIGITS nibbles.
// Ports:
//   acc_in  - current BCD accumulator, DIGITS packed nibbles
//   bit_in  - next binary bit, enters accumulator bit 0
//   acc_out - corrected and shifted accumulator
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [BCD_NIBBLE_W*DIGITS-1:0] acc_in,
  input  logic                           bit_in,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] acc_out
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;

  logic [BCD_W-1:0] adj;
  logic             unused_msb;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] >= 4'd5) begin
        adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = acc_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] + 4'd3;
      end else begin
        adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] = acc_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W];
      end
    end
  end

  // The top bit falls off the shift; a legal DIGITS setting keeps it zero.
  assign unused_msb = adj[BCD_W-1];
  assign acc_out    = {adj[BCD_W-2:0], bit_in};

endmodule

// File: rtl/seq_bin_to_bcd.sv
// rtl/seq_bin_to_bcd.sv - multi-cycle signed/unsigned binary-to-BCD converter, one bit per clock
// Purpose: accepts a binary value, converts its magnitude in BIN_W cycles, and
//   presents packed BCD digits plus a sign flag with valid/ready on both sides.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - bin is valid
//   in_ready  - block can accept a new value (combinational from state/out_ready)
//   bin       - binary value to convert
//   out_valid - bcd/neg hold a completed result
//   out_ready - consumer accepts the result
//   bcd       - packed digits, most significant digit at the top nibble
//   neg       - result is negative (always 0 when SIGNED=0)
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 15,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIN_W-1:0]               bin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd,
  output logic                           neg
);

  localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // A signed magnitude never exceeds 2^(BIN_W-1), which lets e.g. a 20-bit
  // signed input fit in 6 digits.
  localparam int MAG_W = (SIGNED != 0) ? BIN_W - 1 : BIN_W;

  if (DIGITS < min_bcd_digits(MAG_W)) begin : g_digits_too_small
    $error("seq_bin_to_bcd: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               neg_q, neg_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   step_acc;
  logic               sign_in;
  logic [BIN_W-1:0]   mag;
  logic               accept;

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .acc_in  (acc_q),
    .bit_in  (shift_q[BIN_W-1]),
    .acc_out (step_acc)
  );

  always_comb begin
    sign_in = (SIGNED != 0) ? bin[BIN_W-1] : 1'b0;
    // BIN_W-bit negate: the most negative input maps to 2^(BIN_W-1) unchanged.
    mag     = sign_in ? (~bin + BIN_W'(1)) : bin;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;

    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          shift_d     = mag;
          sign_d      = sign_in;
          acc_d       = '0;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = CONV;
        end
      end
      CONV: begin
        acc_d   = step_acc;
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d       = step_acc;
          neg_d       = sign_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb/tb_seq_bin_to_bcd.sv - self-checking bench for seq_bin_to_bcd
module tb_seq_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n;

  // default instance: BIN_W=15, DIGITS=5, SIGNED=1
  logic        in_valid, in_ready, out_valid, out_ready, neg;
  logic [14:0] bin;
  logic [19:0] bcd;

  // unsigned 15-bit, signed 8-bit, signed 20-bit instances
  logic        aux_ready = 1'b1;
  logic        u_in_valid, u_in_ready, u_out_valid, u_neg;
  logic [14:0] u_bin;
  logic [19:0] u_bcd;
  logic        s_in_valid, s_in_ready, s_out_valid, s_neg;
  logic [7:0]  s_bin;
  logic [11:0] s_bcd;
  logic        w_in_valid, w_in_ready, w_out_valid, w_neg;
  logic [19:0] w_bin;
  logic [23:0] w_bcd;

  logic [2:0]  aux_valid;
  logic [2:0]  aux_neg;
  logic [23:0] aux_bcd [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_bin_to_bcd dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .neg(neg)
  );

  seq_bin_to_bcd #(.BIN_W(15), .DIGITS(5), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .bin(u_bin),
    .out_valid(u_out_valid), .out_ready(aux_ready), .bcd(u_bcd), .neg(u_neg)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .bin(s_bin),
    .out_valid(s_out_valid), .out_ready(aux_ready), .bcd(s_bcd), .neg(s_neg)
  );

  seq_bin_to_bcd #(.BIN_W(20), .DIGITS(6), .SIGNED(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .bin(w_bin),
    .out_valid(w_out_valid), .out_ready(aux_ready), .bcd(w_bcd), .neg(w_neg)
  );

  assign aux_valid  = {w_out_valid, s_out_valid, u_out_valid};
  assign aux_neg    = {w_neg, s_neg, u_neg};
  assign aux_bcd[0] = {4'h0, u_bcd};
  assign aux_bcd[1] = {12'h000, s_bcd};
  assign aux_bcd[2] = w_bcd;

  typedef struct {
    logic [14:0] bin;
    logic [19:0] bcd;
    logic        neg;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent decimal reference: digit extraction by division.
  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Called just after a falling edge; accepts b on the next rising edge and
  // waits (bounded) for the result on the default instance.
  task automatic main_conv(input string tag, input logic [14:0] b);
    int   lat;
    logic ir_bad;
    in_valid = 1'b1;
    bin      = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    ir_bad   = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'd15);
    check({tag, " in_ready_conv"}, {31'd0, ir_bad}, 32'd0);
  endtask

  task automatic run_aux(input int which, input string tag, input logic [19:0] b,
                         input logic [23:0] exp_bcd, input logic exp_neg, input int exp_lat);
    int lat;
    case (which)
      0:       begin u_bin = b[14:0]; u_in_valid = 1'b1; end
      1:       begin s_bin = b[7:0];  s_in_valid = 1'b1; end
      default: begin w_bin = b;       w_in_valid = 1'b1; end
    endcase
    @(posedge clk);
    @(negedge clk);
    u_in_valid = 1'b0;
    s_in_valid = 1'b0;
    w_in_valid = 1'b0;
    lat = 0;
    while (!aux_valid[which] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " bcd"}, {8'h0, aux_bcd[which]}, {8'h0, exp_bcd});
    check({tag, " neg"}, {31'd0, aux_neg[which]}, {31'd0, exp_neg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ov_seen;
    logic [7:0]  r;
    int unsigned mag;

    vecs[0] = '{15'd12345, 20'h12345, 1'b0};
    vecs[1] = '{15'h7FFF,  20'h00001, 1'b1};
    vecs[2] = '{15'h4000,  20'h16384, 1'b1};
    vecs[3] = '{15'h3FFF,  20'h16383, 1'b0};
    vecs[4] = '{15'h0000,  20'h00000, 1'b0};
    vecs[5] = '{15'h7C19,  20'h00999, 1'b1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    bin        = '0;
    u_in_valid = 1'b0; u_bin = '0;
    s_in_valid = 1'b0; s_bin = '0;
    w_in_valid = 1'b0; w_bin = '0;

    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset bcd", {12'd0, bcd}, 32'd0);
    check("reset neg", {31'd0, neg}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      main_conv($sformatf("vec%0d", i), vecs[i].bin);
      check($sformatf("vec%0d bcd", i), {12'd0, bcd}, {12'd0, vecs[i].bcd});
      check($sformatf("vec%0d neg", i), {31'd0, neg}, {31'd0, vecs[i].neg});
    end

    // Backpressure: hold the result for 10 cycles, then hand off and accept together.
    @(negedge clk);
    out_ready = 1'b0;
    main_conv("bp", 15'd12345);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp hold%0d bcd", i), {12'd0, bcd}, 32'h12345);
      check($sformatf("bp hold%0d in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready on out_ready", {31'd0, in_ready}, 32'd1);
    main_conv("bp next", 15'd42);
    check("bp next bcd", {12'd0, bcd}, 32'h00042);
    check("bp next neg", {31'd0, neg}, 32'd0);

    // Reset during the 7th conversion cycle.
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 15'd12345;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset bcd", {12'd0, bcd}, 32'd0);
    check("midreset neg", {31'd0, neg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    check("midreset spurious out_valid", {31'd0, ov_seen}, 32'd0);
    main_conv("after reset", 15'd999);
    check("after reset bcd", {12'd0, bcd}, 32'h00999);
    check("after reset neg", {31'd0, neg}, 32'd0);

    // Unsigned 15-bit instance.
    run_aux(0, "u 7fff", 20'h07FFF, 24'h032767, 1'b0, 15);
    run_aux(0, "u zero", 20'h00000, 24'h000000, 1'b0, 15);
    run_aux(0, "u 12345", 20'd12345, 24'h012345, 1'b0, 15);

    // Signed 8-bit instance: corners then random values against the reference.
    run_aux(1, "s8 80", 20'h00080, 24'h000128, 1'b1, 8);
    run_aux(1, "s8 7f", 20'h0007F, 24'h000127, 1'b0, 8);
    run_aux(1, "s8 ff", 20'h000FF, 24'h000001, 1'b1, 8);
    run_aux(1, "s8 00", 20'h00000, 24'h000000, 1'b0, 8);
    for (int i = 0; i < 12; i++) begin
      r   = 8'($urandom_range(0, 255));
      mag = r[7] ? (256 - int'(r)) : int'(r);
      run_aux(1, $sformatf("s8 rand %02h", r), {12'h000, r}, to_bcd(mag), r[7], 8);
    end

    // Signed 20-bit instance with 6 digits.
    run_aux(2, "w20 min", 20'h80000, 24'h524288, 1'b1, 20);
    run_aux(2, "w20 max", 20'h7FFFF, 24'h524287, 1'b0, 20);
    run_aux(2, "w20 -1", 20'hFFFFF, 24'h000001, 1'b1, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
